// File: rtl/led_matrix_pkg.sv
// Shared constants and types for the 4x4 LED matrix datapath.
// Used by the frame serializer and its slot counter.
package led_matrix_pkg;

    localparam int LED_NUM    = 16;
    localparam int LED_SLOT_W = 5;
    localparam int LED_PERIOD = LED_NUM + 1;

    typedef logic [LED_NUM-1:0] led_frame_t;

endpackage

// File: rtl/led_slot_counter.sv
// Free-running 0..NUM_LEDS scan slot counter with a wrap strobe.
// Also exposes the next slot so callers can register per-slot data.
module led_slot_counter
    import led_matrix_pkg::*;
#(
    parameter int NUM_LEDS = LED_NUM,
    parameter int SLOT_W   = LED_SLOT_W
) (
    input  logic              clk,
    input  logic              rst,
    output logic [SLOT_W-1:0] slot,
    output logic [SLOT_W-1:0] slot_next,
    output logic              wrap
);

    localparam logic [SLOT_W-1:0] LAST = SLOT_W'(NUM_LEDS);

    logic [SLOT_W-1:0] slot_q;
    logic [SLOT_W-1:0] slot_d;

    always_comb begin
        wrap   = (slot_q == LAST);
        slot_d = wrap ? '0 : slot_q + SLOT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slot      = slot_q;
    assign slot_next = slot_d;

endmodule

// File: rtl/led_frame_serializer.sv
// Double-buffered LED frame serializer feeding the scan driver one bit per slot.
// Define LFS_BLANK_EN to add the `blank` input that forces data_led low.
module led_frame_serializer
    import led_matrix_pkg::*;
#(
    parameter int NUM_LEDS = LED_NUM,
    parameter int SLOT_W   = LED_SLOT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_LEDS-1:0] frame_data,
    input  logic                frame_valid,
    output logic                frame_ready,
    output logic                data_led,
    output logic [SLOT_W-1:0]   slot,
    output logic                frame_start
`ifdef LFS_BLANK_EN
    ,
    input  logic                blank
`endif
);

    logic [SLOT_W-1:0]   slot_nxt;
    logic                wrap;

    logic [NUM_LEDS-1:0] active_q, active_d;
    logic [NUM_LEDS-1:0] shadow_q, shadow_d;
    logic                shadow_full_q, shadow_full_d;
    logic                swapped_q, swapped_d;
    logic                data_led_q, data_led_d;
    logic                frame_start_q, frame_start_d;

    logic                accept;
    logic                swap;
    logic [NUM_LEDS-1:0] led_shift;
    logic                led_off;

    led_slot_counter #(
        .NUM_LEDS (NUM_LEDS),
        .SLOT_W   (SLOT_W)
    ) u_slot (
        .clk       (clk),
        .rst       (rst),
        .slot      (slot),
        .slot_next (slot_nxt),
        .wrap      (wrap)
    );

`ifdef LFS_BLANK_EN
    assign led_off = blank;
`else
    assign led_off = 1'b0;
`endif

    // Swap needs a full shadow, accept needs an empty one: never both.
    always_comb begin
        accept        = frame_valid & ~shadow_full_q;
        swap          = wrap & shadow_full_q;
        active_d      = swap ? shadow_q : active_q;
        shadow_d      = accept ? frame_data : shadow_q;
        shadow_full_d = shadow_full_q;
        if (swap) begin
            shadow_full_d = 1'b0;
        end else if (accept) begin
            shadow_full_d = 1'b1;
        end
        swapped_d     = swap;
        frame_start_d = swapped_q;
        led_shift     = active_d >> (slot_nxt - SLOT_W'(1));
        data_led_d    = (slot_nxt != '0) & led_shift[0] & ~led_off;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q      <= '0;
            shadow_q      <= '0;
            shadow_full_q <= 1'b0;
            swapped_q     <= 1'b0;
            data_led_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            active_q      <= active_d;
            shadow_q      <= shadow_d;
            shadow_full_q <= shadow_full_d;
            swapped_q     <= swapped_d;
            data_led_q    <= data_led_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign frame_ready = ~shadow_full_q;
    assign data_led    = data_led_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_led_frame_serializer.sv
// Scoreboard bench for led_frame_serializer: accepted frames are queued
// with their due frame_start edge and checked bit by bit as they are shown.
module tb_led_frame_serializer;

    logic        clk;
    logic        rst;
    logic [15:0] frame_data;
    logic        frame_valid;
    logic        frame_ready;
    logic        data_led;
    logic [4:0]  slot;
    logic        frame_start;
    logic        blank;

    led_frame_serializer dut (
        .clk         (clk),
        .rst         (rst),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .data_led    (data_led),
        .slot        (slot),
        .frame_start (frame_start)
`ifdef LFS_BLANK_EN
        ,
        .blank       (blank)
`endif
    );

    typedef struct {
        logic [15:0] frame;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          exp_slot = 0;
    int          edge_n   = 0;
    int          acc_count = 0;
    int          last_due = 0;
    int          last_acc_edge = 0;
    int          last_fs_edge = 0;
    logic [15:0] cur_frame = '0;
    logic        hs_acc = 1'b0;
    logic [15:0] hs_data = '0;
    logic        blank_s = 1'b0;
    logic        blank_en = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs change only on negedge, so this reflects the next posedge.
    always @(negedge clk) begin
        #1;
        hs_acc  = frame_valid && frame_ready && !rst;
        hs_data = frame_data;
`ifdef LFS_BLANK_EN
        blank_s = blank;
`else
        blank_s = 1'b0;
`endif
    end

    always @(negedge clk) begin
        blank = blank_en && (exp_slot >= 4) && (exp_slot <= 7);
    end

    always @(posedge clk) begin
        int   pre;
        int   w;
        logic exp_fs;
        logic exp_led;
        logic exp_rdy;
        if (!rst) begin
            edge_n++;
            pre = exp_slot;
            if (hs_acc) begin
                w = (pre == 16) ? edge_n + 17 : edge_n + (16 - pre);
                sb.push_back('{hs_data, w + 1});
                last_due      = w + 1;
                last_acc_edge = edge_n;
                acc_count++;
            end
            exp_slot = (pre == 16) ? 0 : pre + 1;
            exp_fs   = 1'b0;
            if (sb.size() > 0 && sb[0].due == edge_n) begin
                cur_frame = sb[0].frame;
                void'(sb.pop_front());
                exp_fs       = 1'b1;
                last_fs_edge = edge_n;
            end
            exp_led = (exp_slot != 0) && cur_frame[exp_slot-1] && !blank_s;
            exp_rdy = (sb.size() == 0) || (edge_n >= sb[0].due - 1);
            #1;
            check("slot", slot, exp_slot);
            check("frame_start", frame_start, exp_fs);
            check("data_led", data_led, exp_led);
            check("frame_ready", frame_ready, exp_rdy);
        end
    end

    task automatic reset_now();
        rst = 1'b1;
        sb.delete();
        cur_frame = '0;
        exp_slot  = 0;
        edge_n    = 0;
        #1;
        check("rst_slot", slot, 0);
        check("rst_data_led", data_led, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_frame_ready", frame_ready, 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] d);
        int start;
        bit got;
        start = acc_count;
        got   = 0;
        @(negedge clk);
        frame_data  = d;
        frame_valid = 1'b1;
        for (int i = 0; i < 60 && !got; i++) begin
            @(posedge clk);
            #2;
            if (acc_count != start) got = 1;
        end
        @(negedge clk);
        frame_valid = 1'b0;
        check("accept_seen", got, 1);
    endtask

    task automatic wait_slot(input int s);
        bit found;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (exp_slot == s) found = 1;
        end
        check("wait_slot", found, 1);
    endtask

    initial begin
        int due1;
        int start;
        rst         = 1'b1;
        frame_data  = '0;
        frame_valid = 1'b0;
        blank       = 1'b0;
        #1;
        check("por_slot", slot, 0);
        check("por_data_led", data_led, 0);
        check("por_frame_ready", frame_ready, 1);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // idle: dark, no frame_start
        repeat (40) @(negedge clk);

        // frame 0x0001 accepted at edge 3, shown at edge 18
        @(negedge clk);
        reset_now();
        @(negedge clk);
        send_frame(16'h0001);
        repeat (40) @(negedge clk);
        check("first_fs_edge", last_fs_edge, 18);

        // back-to-back frames; second waits for the swap
        send_frame(16'hA5A5);
        due1 = last_due;
        send_frame(16'hFFFF);
        check("acc_after_swap", last_acc_edge, due1);
        repeat (40) @(negedge clk);

        // accept exactly on the wrap edge with an empty shadow
        wait_slot(16);
        start       = acc_count;
        frame_data  = 16'h3C0F;
        frame_valid = 1'b1;
        @(posedge clk);
        #2;
        check("wrap_accept", acc_count - start, 1);
        @(negedge clk);
        frame_valid = 1'b0;
        repeat (40) @(negedge clk);

        // reset at slot 9 with a frame pending in the shadow
        wait_slot(1);
        send_frame(16'h1234);
        wait_slot(9);
        check("pending_before_rst", frame_ready, 0);
        reset_now();
        repeat (40) @(negedge clk);

`ifdef LFS_BLANK_EN
        send_frame(16'hFFFF);
        repeat (20) @(negedge clk);
        blank_en = 1'b1;
        repeat (40) @(negedge clk);
        blank_en = 1'b0;
        repeat (5) @(negedge clk);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
